// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel pipeline: default frame geometry,
// coordinate/depth widths and the scan-state encoding.
package mandelbrot_pkg;

    localparam int FRAC_DEF  = 16;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam int CW = 32;  // coordinate word
    localparam int DW = 10;  // depth
    localparam int XW = 10;  // x counter
    localparam int YW = 9;   // y counter

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_OUTPUT
    } scan_state_t;

endpackage

// File: rtl/pixel_scan_controller_if.sv
// Pixel depth stream (valid/ready) from the scan controller to colour mapping.
// Signals: m_tdata depth, m_tvalid, m_tready, m_tuser start-of-frame, m_tlast end-of-line.
interface pixel_scan_controller_if;
    import mandelbrot_pkg::*;

    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tuser;
    logic          m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tuser,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tuser,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/coord_stepper.sv
// Complex-plane accumulator for the raster scan: loads the frame origin/step,
// advances re by step along a line and returns re / lowers im at each new line.
// Ports: sysclk, reset (async high), i_load, i_adv_x, i_adv_line,
//        i_re_origin, i_im_origin, i_step, o_re_c, o_im_c.
module coord_stepper
    import mandelbrot_pkg::*;
(
    input  logic          sysclk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_adv_x,
    input  logic          i_adv_line,
    input  logic [CW-1:0] i_re_origin,
    input  logic [CW-1:0] i_im_origin,
    input  logic [CW-1:0] i_step,
    output logic [CW-1:0] o_re_c,
    output logic [CW-1:0] o_im_c
);

    logic [CW-1:0] r_re0;
    logic [CW-1:0] r_step;
    logic [CW-1:0] r_re_c;
    logic [CW-1:0] r_im_c;

    // Origin and step are frozen at load so input changes only affect the
    // next frame. Adds wrap silently in two's complement.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_re0  <= '0;
            r_step <= '0;
            r_re_c <= '0;
            r_im_c <= '0;
        end else if (i_load) begin
            r_re0  <= i_re_origin;
            r_step <= i_step;
            r_re_c <= i_re_origin;
            r_im_c <= i_im_origin;
        end else if (i_adv_x) begin
            r_re_c <= r_re_c + r_step;
        end else if (i_adv_line) begin
            r_re_c <= r_re0;
            r_im_c <= r_im_c - r_step;
        end
    end

    assign o_re_c = r_re_c;
    assign o_im_c = r_im_c;

endmodule

// File: rtl/pixel_scan_controller.sv
// Raster-order frame sequencer: launches one depth calculation per pixel and
// streams each depth out with start-of-frame / end-of-line markers.
// Ports: sysclk, reset (async high), enable, re_origin, im_origin, step,
//        calc_* (calculator start/done handshake), m_axis (pixel stream), frame_done.
module pixel_scan_controller
    import mandelbrot_pkg::*;
#(
    parameter int FRAC  = FRAC_DEF,
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CW-1:0]         re_origin,
    input  logic [CW-1:0]         im_origin,
    input  logic [CW-1:0]         step,
    output logic                  calc_start,
    output logic [XW-1:0]         calc_x,
    output logic [YW-1:0]         calc_y,
    output logic [CW-1:0]         calc_re_c,
    output logic [CW-1:0]         calc_im_c,
    input  logic                  calc_done,
    input  logic [DW-1:0]         calc_depth,
    pixel_scan_controller_if.master m_axis,
    output logic                  frame_done
);

    // FRAC only fixes the meaning of the coordinate words; the datapath is
    // pure add/subtract, so it just has to leave room for an integer part.
    if (FRAC < 1 || FRAC > CW - 1) begin : g_frac_chk
        $error("pixel_scan_controller: FRAC out of range");
    end

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    scan_state_t r_state;
    scan_state_t w_next;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [DW-1:0] r_depth;
    logic          r_first;
    logic          r_fdone;

    logic w_load;
    logic w_adv_x;
    logic w_adv_line;
    logic w_capture;
    logic w_start;
    logic w_valid;
    logic w_fdone;
    logic w_x_last;
    logic w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_adv_x    = 1'b0;
        w_adv_line = 1'b0;
        w_capture  = 1'b0;
        w_start    = 1'b0;
        w_valid    = 1'b0;
        w_fdone    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_load = 1'b1;
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_start = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                // The first WAIT cycle may still see the previous pixel's
                // done level, so it is never trusted.
                if (!r_first && calc_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_valid = 1'b1;
                if (m_axis.m_tready) begin
                    if (!w_x_last) begin
                        w_adv_x = 1'b1;
                        w_next  = ST_LAUNCH;
                    end else if (!w_y_last) begin
                        w_adv_line = 1'b1;
                        w_next     = ST_LAUNCH;
                    end else begin
                        w_fdone = 1'b1;
                        w_next  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_depth <= '0;
            r_first <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_fdone <= w_fdone;
            if (w_start) begin
                r_first <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_first <= 1'b0;
            end
            if (w_capture) begin
                r_depth <= calc_depth;
            end
            if (w_load) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_adv_x) begin
                r_x <= r_x + 1'b1;
            end else if (w_adv_line) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end
        end
    end

    coord_stepper u_coord (
        .sysclk      (sysclk),
        .reset       (reset),
        .i_load      (w_load),
        .i_adv_x     (w_adv_x),
        .i_adv_line  (w_adv_line),
        .i_re_origin (re_origin),
        .i_im_origin (im_origin),
        .i_step      (step),
        .o_re_c      (calc_re_c),
        .o_im_c      (calc_im_c)
    );

    assign calc_start = w_start;
    assign calc_x     = r_x;
    assign calc_y     = r_y;
    assign frame_done = r_fdone;

    // Markers are qualified by OUTPUT so they read 0 outside a beat,
    // including straight after reset where x=y=0.
    assign m_axis.m_tdata  = r_depth;
    assign m_axis.m_tvalid = w_valid;
    assign m_axis.m_tuser  = w_valid && (r_x == '0) && (r_y == '0);
    assign m_axis.m_tlast  = w_valid && w_x_last;

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Directed bench for pixel_scan_controller on a 4x3 frame with a
// fixed-latency calculator model.
module tb_pixel_scan_controller;
    import mandelbrot_pkg::*;

    localparam int HR  = 4;
    localparam int VR  = 3;
    localparam int LAT = 5;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          enable;
    logic [31:0]   re_origin;
    logic [31:0]   im_origin;
    logic [31:0]   step;
    logic          calc_start;
    logic [9:0]    calc_x;
    logic [8:0]    calc_y;
    logic [31:0]   calc_re_c;
    logic [31:0]   calc_im_c;
    logic          calc_done = 1'b0;
    logic [9:0]    calc_depth = '0;
    logic          frame_done;

    pixel_scan_controller_if axis ();

    always #5 sysclk = ~sysclk;

    pixel_scan_controller #(
        .FRAC  (16),
        .H_RES (HR),
        .V_RES (VR)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .re_origin  (re_origin),
        .im_origin  (im_origin),
        .step       (step),
        .calc_start (calc_start),
        .calc_x     (calc_x),
        .calc_y     (calc_y),
        .calc_re_c  (calc_re_c),
        .calc_im_c  (calc_im_c),
        .calc_done  (calc_done),
        .calc_depth (calc_depth),
        .m_axis     (axis.master),
        .frame_done (frame_done)
    );

    // Calculator model: depth = x + 4*y + 1, ready LAT cycles after start.
    // stale_mode keeps the old done level up for one cycle after the start.
    logic     stale_mode = 1'b0;
    int       mdl_cnt = 0;
    logic     mdl_clr = 1'b0;
    logic [9:0] mdl_val = '0;

    always @(posedge sysclk) begin
        if (calc_start) begin
            mdl_cnt <= LAT;
            mdl_val <= 10'(int'(calc_x) + 4 * int'(calc_y) + 1);
            if (!stale_mode) calc_done <= 1'b0;
            mdl_clr <= stale_mode;
        end else begin
            if (mdl_clr) begin
                calc_done <= 1'b0;
                mdl_clr   <= 1'b0;
            end
            if (mdl_cnt == 1) begin
                calc_done  <= 1'b1;
                calc_depth <= mdl_val;
            end
            if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
        end
    end

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [31:0] re;
        logic [31:0] im;
        logic [9:0]  tdata;
        logic        tuser;
        logic        tlast;
    } beat_t;

    beat_t beats[$];
    beat_t exp_tab[12];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_starts = 0;
    int    n_fdone  = 0;

    always @(negedge sysclk) begin
        if (axis.m_tvalid && axis.m_tready)
            beats.push_back('{calc_x, calc_y, calc_re_c, calc_im_c,
                              axis.m_tdata, axis.m_tuser, axis.m_tlast});
        if (calc_start) n_starts++;
        if (frame_done) n_fdone++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_fdone(input string name);
        int f0;
        f0 = n_fdone;
        for (int i = 0; i < 3000 && n_fdone == f0; i++) tick();
        chk(name, 64'(n_fdone != f0), 1);
    endtask

    task automatic wait_beats(input string name, input int n);
        for (int i = 0; i < 3000 && beats.size() < n; i++) tick();
        chk(name, 64'(beats.size() >= n), 1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nbeats"}, 64'(beats.size()), 12);
        for (int i = 0; i < 12 && i < beats.size(); i++) begin
            chk($sformatf("%s_b%0d_x", tag, i), 64'(beats[i].x), 64'(exp_tab[i].x));
            chk($sformatf("%s_b%0d_y", tag, i), 64'(beats[i].y), 64'(exp_tab[i].y));
            chk($sformatf("%s_b%0d_re", tag, i), 64'(beats[i].re), 64'(exp_tab[i].re));
            chk($sformatf("%s_b%0d_im", tag, i), 64'(beats[i].im), 64'(exp_tab[i].im));
            chk($sformatf("%s_b%0d_tdata", tag, i), 64'(beats[i].tdata), 64'(exp_tab[i].tdata));
            chk($sformatf("%s_b%0d_tuser", tag, i), 64'(beats[i].tuser), 64'(exp_tab[i].tuser));
            chk($sformatf("%s_b%0d_tlast", tag, i), 64'(beats[i].tlast), 64'(exp_tab[i].tlast));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, 64'(calc_start), 0);
        chk({tag, "_xy"}, 64'({calc_x, calc_y}), 0);
        chk({tag, "_re"}, 64'(calc_re_c), 0);
        chk({tag, "_im"}, 64'(calc_im_c), 0);
        chk({tag, "_tvalid"}, 64'(axis.m_tvalid), 0);
        chk({tag, "_tdata"}, 64'(axis.m_tdata), 0);
        chk({tag, "_tuser_tlast"}, 64'({axis.m_tuser, axis.m_tlast}), 0);
        chk({tag, "_fdone"}, 64'(frame_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] re_t[4];
        logic [31:0] im_t[3];
        int s0;
        int f0;

        // -2.0, -1.75, -1.5, -1.25 and 1.0, 0.75, 0.5 in Q16.16
        re_t = '{32'hFFFE0000, 32'hFFFE4000, 32'hFFFE8000, 32'hFFFEC000};
        im_t = '{32'h00010000, 32'h0000C000, 32'h00008000};
        for (int i = 0; i < 12; i++)
            exp_tab[i] = '{10'(i % 4), 9'(i / 4), re_t[i % 4], im_t[i / 4],
                           10'(i + 1), (i == 0), ((i % 4) == 3)};

        reset         = 1'b1;
        enable        = 1'b0;
        re_origin     = 32'hFFFE0000;
        im_origin     = 32'h00010000;
        step          = 32'h00004000;
        axis.m_tready = 1'b1;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // Frame sweep
        beats.delete();
        s0 = n_starts;
        f0 = n_fdone;
        start_frame();
        wait_fdone("f1_done");
        for (int i = 0; i < 10; i++) tick();
        check_frame("f1");
        chk("f1_fdone_once", 64'(n_fdone - f0), 1);
        chk("f1_starts", 64'(n_starts - s0), 12);

        // Stale done level plus origin change mid-frame
        stale_mode = 1'b1;
        beats.delete();
        start_frame();
        for (int i = 0; i < 2000 && !(calc_start && calc_x == 1 && calc_y == 1); i++)
            tick();
        chk("f2_reach_11", 64'(calc_start && calc_x == 1 && calc_y == 1), 1);
        re_origin = 32'h00000000;
        wait_fdone("f2_done");
        check_frame("f2");
        chk("f2_stale_depth", 64'(beats[6].tdata), 7);

        // New origin picked up; backpressure at (3,0); enable held high
        beats.delete();
        enable = 1'b1;
        wait_beats("f3_first", 1);
        chk("f3_new_re", 64'(beats[0].re), 0);
        chk("f3_new_im", 64'(beats[0].im), 64'h10000);
        for (int i = 0; i < 2000 && !(calc_start && calc_x == 3); i++) tick();
        chk("f3_reach_30", 64'(calc_start && calc_x == 3 && calc_y == 0), 1);
        axis.m_tready = 1'b0;
        for (int i = 0; i < 2000 && !axis.m_tvalid; i++) tick();
        s0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_hold", i),
                64'({axis.m_tvalid, axis.m_tuser, axis.m_tlast, axis.m_tdata, calc_x}),
                64'({1'b1, 1'b0, 1'b1, 10'd4, 10'd3}));
            tick();
        end
        chk("bp_no_start", 64'(n_starts - s0), 0);
        axis.m_tready = 1'b1;
        wait_fdone("f3_done");
        tick();
        chk("f3_backtoback", 64'(calc_start), 1);
        enable = 1'b0;

        // Reset in WAIT at (2,1) of frame 4
        for (int i = 0; i < 2000 && !(calc_start && calc_x == 2 && calc_y == 1); i++)
            tick();
        chk("f4_reach_21", 64'(calc_start && calc_x == 2 && calc_y == 1), 1);
        tick();
        f0 = n_fdone;
        reset = 1'b1;
        #1;
        check_all_zero("mrst");
        tick();
        reset = 1'b0;
        beats.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_no_fdone", 64'(n_fdone - f0), 0);
        start_frame();
        wait_beats("f5_first", 1);
        chk("f5_sof", 64'({beats[0].tuser, beats[0].x, beats[0].y}),
            64'({1'b1, 10'd0, 9'd0}));
        wait_fdone("f5_done");

        // Two's-complement wrap
        stale_mode = 1'b0;
        re_origin  = 32'h7FFFFFF0;
        im_origin  = 32'h00000000;
        step       = 32'h00000020;
        beats.delete();
        start_frame();
        wait_fdone("wrap_done");
        chk("wrap_re0", 64'(beats[0].re), 64'h7FFFFFF0);
        chk("wrap_re1", 64'(beats[1].re), 64'h80000010);
        chk("wrap_im_line1", 64'(beats[4].im), 64'hFFFFFFE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_scan_controller.md
# pixel_scan_controller

Frame-level sequencer upstream of the Mandelbrot depth calculator. It scans the screen in raster order and converts each (x, y) to a fixed-point complex coordinate c. It launches one depth calculation per pixel through the calculator's start/done handshake, then emits each resulting depth on a valid/ready pixel stream for the colour-mapping and video stage.

## Interface
Parameters:
- FRAC, 16: fractional bits of all Q-format coordinates (32-bit signed words).
- H_RES, 640: pixels per line; x counter 10 bits.
- V_RES, 480: lines per frame; y counter 9 bits.

Ports:
- sysclk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock sysclk.
- enable  in  1  frame-start request; sampled only in IDLE.
- re_origin  in  32  signed Q(32-FRAC).FRAC real part of pixel (0,0), top-left.
- im_origin  in  32  signed imaginary part of pixel (0,0).
- step  in  32  signed per-pixel increment, same format.
- calc_start  out  1  one-cycle launch pulse to depth calculator.
- calc_x  out  10  current pixel x.
- calc_y  out  9  current pixel y.
- calc_re_c  out  32  real part of c for current pixel.
- calc_im_c  out  32  imaginary part of c for current pixel.
- calc_done  in  1  calculator finished (level; stays high until its next start).
- calc_depth  in  10  calculator result, valid while calc_done high.
- m_tdata  out  10  pixel depth.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tuser  out  1  start of frame, high with pixel (0,0).
- m_tlast  out  1  end of line, high with x = H_RES-1.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- States: IDLE, LAUNCH, WAIT, OUTPUT.
- IDLE: when enable is 1, latch re_origin, im_origin and step into frame registers. Set x=0, y=0, re_c=re_origin, im_c=im_origin. Next state LAUNCH.
- LAUNCH: calc_start=1 for exactly this cycle. Next state WAIT.
- WAIT: calc_done is ignored in the first WAIT cycle, because a stale done level from the previous pixel may still be high. From the second cycle on, calc_done=1 captures calc_depth into m_tdata. Next state OUTPUT.
- OUTPUT: m_tvalid=1. m_tdata, m_tuser and m_tlast are held stable until m_tready=1. On handshake:
  - x < H_RES-1: x+1, re_c += step. Next state LAUNCH.
  - x = H_RES-1, y < V_RES-1: x=0, y+1, re_c = latched re_origin, im_c -= step. Next state LAUNCH.
  - x = H_RES-1, y = V_RES-1: pulse frame_done. Next state IDLE.
- Arithmetic: 32-bit two's-complement add/subtract with silent wrap and no saturation. There are no multiplies. Imaginary part decreases downward.
- calc_x, calc_y, calc_re_c and calc_im_c change only on an OUTPUT handshake or on the IDLE latch. They are stable from LAUNCH through WAIT.
- Origin/step input changes mid-frame have no effect until the next IDLE latch.
- enable deasserted mid-frame: the frame still completes. enable held high: the next frame starts directly after IDLE (one IDLE cycle).
- calc_depth is passed through unmodified.

## Timing
- Reset values: every output is 0, state is IDLE, and the x/y/coordinate/frame registers are 0.
- Reset mid-frame returns to IDLE immediately. No frame_done is produced, and the partial frame is abandoned.
- Per-pixel cycles: 1 (LAUNCH) + calculator latency + 1 (capture) + at least 1 (OUTPUT, longer under backpressure).
- calc_start is never reasserted before the current pixel's OUTPUT handshake.
- Because OUTPUT lasts at least one cycle, the calculator has returned to its idle state before the next launch.
- m_tvalid is never deasserted without a handshake.
- frame_done is registered and high in the cycle after the final handshake, while the state is IDLE.

## Structure
- Shared package mandelbrot_pkg holds:
  - FRAC, H_RES and V_RES defaults;
  - coordinate and depth widths (32, 10, 10, 9);
  - the scan-state enum (IDLE, LAUNCH, WAIT, OUTPUT).
- One sub-module, coord_stepper: the re_c/im_c accumulator with load (origin) and advance-x / advance-line controls.
- The depth calculator is instantiated alongside at the parent level, not inside this block.

## Test plan
All scenarios use H_RES=4, V_RES=3 and a behavioural calculator model with a fixed 5-cycle latency.
- Frame sweep: re_origin=-2.0, im_origin=1.0, step=0.25, m_tready=1.
  - Coordinates: pixel (3,0) has re_c=-1.25. Pixel (0,1) has re_c=-2.0, im_c=0.75.
  - Stream: 12 beats. tuser only on beat 0; tlast on beats 3, 7, 11.
  - frame_done pulses once.
- Stale-done guard: model holds calc_done high before the launch, clears it one cycle after calc_start, and returns depth=7 → m_tdata is 7, not the previous depth.
- Backpressure: m_tready=0 for 10 cycles in OUTPUT → tdata/tuser/tlast stable, no new calc_start, x unchanged.
- Mid-frame input change: change re_origin at pixel (1,1) → remaining pixels still use the latched origin. The next frame uses the new value.
- Reset at pixel (2,1) in WAIT → all outputs 0 next cycle, no frame_done. Re-enable restarts at (0,0) with tuser=1.
- Wrap: re_origin=0x7FFFFFF0, step=0x20 → pixel (1,0) re_c = 0x80000010.
